// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler: FSM encoding, program-entry
// layout and engine identifiers.
package layer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Program entry layout as written through cfg_data.
    localparam int CFG_W        = 3;
    localparam int CFG_ID_LSB   = 0;
    localparam int CFG_ID_W     = 2;
    localparam int CFG_LAST_BIT = 2;

    typedef logic [CFG_ID_W-1:0] eng_id_t;

    localparam eng_id_t ENG_CONV = 2'd0;
    localparam eng_id_t ENG_POOL = 2'd1;
    localparam eng_id_t ENG_RELU = 2'd2;
    localparam eng_id_t ENG_FC   = 2'd3;

    typedef struct packed {
        logic    last;
        eng_id_t id;
    } prog_entry_t;

    function automatic prog_entry_t decode_entry(input logic [CFG_W-1:0] raw);
        prog_entry_t e;
        e.last = raw[CFG_LAST_BIT];
        e.id   = raw[CFG_ID_LSB +: CFG_ID_W];
        return e;
    endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Engine-side and DRAM-side bus of the layer scheduler; master is the
// scheduler, slave is the engine/DRAM fabric.
interface layer_sched_if #(
    parameter int NUM_ENG    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
) ();

    logic [NUM_ENG-1:0]            eng_enable;
    logic [NUM_ENG-1:0]            eng_done;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out;
    logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out;
    logic [NUM_ENG-1:0]            eng_en_rd;
    logic [NUM_ENG-1:0]            eng_en_wr;

    logic [ADDR_WIDTH-1:0]         dram_addr_rd;
    logic [ADDR_WIDTH-1:0]         dram_addr_wr;
    logic [DATA_WIDTH-1:0]         dram_data_wr;
    logic                          dram_en_rd;
    logic                          dram_en_wr;

    modport master (
        output eng_enable,
        input  eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr,
        output dram_addr_rd, dram_addr_wr, dram_data_wr, dram_en_rd, dram_en_wr
    );

    modport slave (
        input  eng_enable,
        output eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr,
        input  dram_addr_rd, dram_addr_wr, dram_data_wr, dram_en_rd, dram_en_wr
    );

endinterface

// File: rtl/layer_sched_dram_mux.sv
// Routes the selected engine's DRAM request to the shared DRAM port; all
// outputs are zero when disabled or when sel names no existing engine.
module dram_mux #(
    parameter int NUM_ENG    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int SEL_W      = 2
) (
    input  logic                          en,
    input  logic [SEL_W-1:0]              sel,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_rd,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_wr,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_wr,
    input  logic [NUM_ENG-1:0]            eng_en_rd,
    input  logic [NUM_ENG-1:0]            eng_en_wr,
    output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
    output logic [ADDR_WIDTH-1:0]         dram_addr_wr,
    output logic [DATA_WIDTH-1:0]         dram_data_wr,
    output logic                          dram_en_rd,
    output logic                          dram_en_wr
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer latches.
    always_comb begin
        dram_addr_rd = '0;
        dram_addr_wr = '0;
        dram_data_wr = '0;
        dram_en_rd   = 1'b0;
        dram_en_wr   = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (en && (int'(sel) == i)) begin
                dram_addr_rd = eng_addr_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
                dram_addr_wr = eng_addr_wr[i*ADDR_WIDTH +: ADDR_WIDTH];
                dram_data_wr = eng_data_wr[i*DATA_WIDTH +: DATA_WIDTH];
                dram_en_rd   = eng_en_rd[i];
                dram_en_wr   = eng_en_wr[i];
            end
        end
    end

endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: walks a small program of engine ids, starts each engine,
// waits for its done pulse and lends it the shared DRAM port meanwhile.
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_ENG    = 4,
    parameter int PROG_DEPTH = 8
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              start,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_addr,
    input  logic [CFG_W-1:0]  cfg_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    layer_sched_if.master     bus
);

    localparam int PC_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    prog_entry_t       prog_q [PROG_DEPTH];
    prog_entry_t       exec_q [PROG_DEPTH];
    prog_entry_t       cur;
    logic [NUM_ENG-1:0] sel_onehot;
    logic              sel_valid;
    logic              cur_last;
    logic              sel_done;
    logic              stray_done;
    logic              start_ok;
    logic              err_set;
    logic              mux_en;

    assign start_ok = start && (state_q == ST_IDLE);

    // Execution reads a snapshot taken at start, so a cfg write in the
    // start cycle lands in prog_q but not in the running program.
    assign cur = exec_q[pc_q];

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (int'(cur.id) == i) sel_onehot[i] = 1'b1;
        end
    end

    assign sel_valid  = |sel_onehot;
    assign cur_last   = cur.last || (int'(pc_q) == PROG_DEPTH - 1);
    assign sel_done   = |(bus.eng_done & sel_onehot);
    assign stray_done = |(bus.eng_done & ~sel_onehot);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_ISSUE;
                    pc_d    = '0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // An invalid engine never answers, so its entry is skipped.
                if (sel_done || !sel_valid) begin
                    if (cur_last) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_ISSUE;
                        pc_d    = pc_q + PC_W'(1);
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: the program store is reset explicitly because an unwritten entry
    // must read as engine 0, not last; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                prog_q[i] <= '0;
                exec_q[i] <= '0;
            end
        end else begin
            if (start_ok) exec_q <= prog_q;
            if (cfg_wr && (state_q == ST_IDLE) && (int'(cfg_addr) < PROG_DEPTH)) begin
                prog_q[cfg_addr] <= decode_entry(cfg_data);
            end
        end
    end

    assign err_set = ((state_q == ST_ISSUE) && !sel_valid) ||
                     ((state_q == ST_WAIT) && stray_done);

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn)        err <= 1'b0;
        else if (err_set)  err <= 1'b1;
        else if (start_ok) err <= 1'b0;
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign bus.eng_enable = (state_q == ST_ISSUE) ? sel_onehot : '0;
    assign mux_en         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    dram_mux #(
        .NUM_ENG    (NUM_ENG),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SEL_W      (CFG_ID_W)
    ) u_dram_mux (
        .en           (mux_en),
        .sel          (cur.id),
        .eng_addr_rd  (bus.eng_addr_in),
        .eng_addr_wr  (bus.eng_addr_out),
        .eng_data_wr  (bus.eng_data_out),
        .eng_en_rd    (bus.eng_en_rd),
        .eng_en_wr    (bus.eng_en_wr),
        .dram_addr_rd (bus.dram_addr_rd),
        .dram_addr_wr (bus.dram_addr_wr),
        .dram_data_wr (bus.dram_data_wr),
        .dram_en_rd   (bus.dram_en_rd),
        .dram_en_wr   (bus.dram_en_wr)
    );

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of the DRAM data path.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 18, width of the DRAM addresses.
REQ-003 The block SHALL have parameter NUM_ENG, default 4, number of layer engines (conv, pool, relu, fc).
REQ-004 The block SHALL have parameter PROG_DEPTH, default 8, number of layer-program entries.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 srstn  in  1  asynchronous active-low reset.
REQ-008 start  in  1  single-cycle pulse that begins program execution.
REQ-009 cfg_wr  in  1  program-entry write strobe.
REQ-010 cfg_addr  in  3  program-entry index.
REQ-011 cfg_data  in  3  program entry: [1:0] engine id, [2] last-layer flag.
REQ-012 eng_enable  out  NUM_ENG  one-hot start pulse to the selected engine.
REQ-013 eng_done  in  NUM_ENG  per-engine done pulse.
REQ-014 eng_addr_in / eng_addr_out  in  NUM_ENG*ADDR_WIDTH  flattened per-engine read and write addresses.
REQ-015 eng_data_out  in  NUM_ENG*DATA_WIDTH  flattened per-engine write data.
REQ-016 eng_en_rd / eng_en_wr  in  NUM_ENG  per-engine DRAM read and write enables.
REQ-017 dram_addr_rd / dram_addr_wr  out  ADDR_WIDTH  DRAM read and write addresses.
REQ-018 dram_data_wr  out  DATA_WIDTH  DRAM write data.
REQ-019 dram_en_rd / dram_en_wr  out  1  DRAM read and write enables.
REQ-020 busy  out  1  high in any state except IDLE.
REQ-021 done  out  1  one-cycle pulse when the program completes.
REQ-022 err  out  1  sticky protocol-error flag.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT and FIN.
- IDLE->ISSUE on start.
- ISSUE->WAIT unconditionally.
- WAIT->ISSUE on eng_done[sel] when the entry is not last.
- WAIT->FIN on eng_done[sel] when the entry is last.
- FIN->IDLE unconditionally.
REQ-024 An entry SHALL be treated as last if its last flag is set or pc==PROG_DEPTH-1.
REQ-025 Program counter pc SHALL clear on entering ISSUE from IDLE and increment on WAIT->ISSUE.
- sel = prog[pc][1:0].
REQ-026 In ISSUE, eng_enable SHALL be one-hot at bit sel for exactly one cycle; it is zero otherwise.
REQ-027 In ISSUE and WAIT, all dram_* outputs SHALL be a combinational mux of engine sel's signals; in IDLE and FIN they are all zero.
REQ-028 Engine ids >= NUM_ENG SHALL set err, be skipped (ISSUE->WAIT->next entry with no enable issued), and leave dram_* zero.
REQ-029 cfg_wr SHALL write prog[cfg_addr] only in IDLE; it is ignored while busy.
REQ-030 start while busy SHALL be ignored.
REQ-031 start and cfg_wr in the same IDLE cycle SHALL both take effect; execution uses the pre-write entry for that address.
REQ-032 err SHALL set when any eng_done bit other than sel is high during WAIT.
REQ-033 err SHALL clear on an accepted start.
- If err sets in the same cycle as an accepted start, set wins.
REQ-034 Latency from start to eng_enable SHALL be 1 cycle.
REQ-035 Latency from eng_done[sel] to the next eng_enable SHALL be 1 cycle.
REQ-036 Latency from the last eng_done to done SHALL be 1 cycle.
REQ-037 eng_done[sel] arriving in the same cycle as WAIT entry SHALL NOT be accepted; only cycles already in WAIT count.

Reset
REQ-038 On srstn low, the following SHALL clear asynchronously:
- state=IDLE, pc=0;
- all prog entries = 0 (id 0, not last);
- eng_enable=0, done=0, err=0, busy=0;
- all dram_* = 0.
REQ-039 Reset mid-program SHALL abandon execution with no done pulse.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding, the cfg_data field positions and the engine-id constants (CONV=0, POOL=1, RELU=2, FC=3).
REQ-041 The DRAM mux SHALL be a sub-module dram_mux (parameterised NUM_ENG, DATA_WIDTH, ADDR_WIDTH, sel input).

Verification
REQ-042 Program entries {2 last} + start -> eng_enable=4'b0100 at cycle+1; eng_done[2] after 10 cycles -> done 1 cycle later; err=0.
REQ-043 Program {0,1,2 last} with 5-cycle engine models -> enables 0001, 0010, 0100 in order; done after the third eng_done; dram_* follow each engine.
REQ-044 Program with no last flag -> exactly 8 issues, then done.
REQ-045 eng_done[1] pulsed while sel=0 -> err=1 and held; the next start clears it.
REQ-046 start and cfg_wr while busy -> ignored; reset asserted in WAIT -> busy=0, dram_* = 0 immediately, no done.
